// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: line write buffer between the data cache and memory, with merge, read forwarding and background drain
module dcache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [ADDR_W-1:0]        up_addr_i,
  input  logic [DATA_W-1:0]        up_data_i,
  input  logic                     up_enable_i,
  input  logic                     up_write_i,
  output logic                     up_ack_o,
  output logic [DATA_W-1:0]        up_data_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_data_o,
  output logic                     mem_enable_o,
  output logic                     mem_write_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  output logic [$clog2(DEPTH):0]   wb_count_o,
  output logic                     wb_empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = ADDR_W - 5;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state, state_d;
  logic [LW-1:0] line_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, rsel, wsel;
  logic [LW-1:0] rd_line, up_line;
  logic rd_pend, rhit, whit, sample, lock, rd_hit, rd_miss, merge, push, pop, rd_done, enter;
  logic up_ack_d, mem_en_d, mem_wr_d, empty_d;
  logic [DATA_W-1:0] up_data_d, mem_data_d;
  logic [ADDR_W-1:0] mem_addr_d;
  assign up_line = up_addr_i[ADDR_W-1:5];
  assign sample  = up_enable_i && !up_ack_o && !rd_pend;
  // head is locked both while draining and in the cycle IDLE launches it
  assign lock    = state == WR || (state == IDLE && wb_count_o != '0);
  always_comb begin
    rhit = 1'b0;
    whit = 1'b0;
    rsel = head;
    wsel = head;
    for (int k = 0; k < DEPTH; k++)
      if ((PW+1)'(k) < wb_count_o && line_q[head + PW'(k)] == up_line) begin
        rhit = 1'b1;
        rsel = head + PW'(k);
        if (k != 0 || !lock) begin
          whit = 1'b1;
          wsel = head + PW'(k);
        end
      end
  end
  assign rd_hit  = sample && !up_write_i && rhit;
  assign rd_miss = sample && !up_write_i && !rhit;
  assign merge   = sample && up_write_i && whit;
  assign push    = sample && up_write_i && !whit && wb_count_o != (PW+1)'(DEPTH);
  assign pop     = state == WR && mem_ack_i;
  assign rd_done = state == RD && mem_ack_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (state == IDLE) state_d = (rd_pend || rd_miss) ? RD : (wb_count_o != '0) ? WR : IDLE;
    else if (mem_ack_i) state_d = IDLE;
  end
  always_comb begin
    enter      = state == IDLE && state_d != IDLE;
    up_ack_d   = rd_hit || merge || push || rd_done;
    up_data_d  = rd_hit ? data_q[rsel] : rd_done ? mem_data_i : up_data_o;
    mem_addr_d = !enter ? mem_addr_o : state_d == RD ? {rd_pend ? rd_line : up_line, 5'b0} : {line_q[head], 5'b0};
    mem_data_d = (enter && state_d == WR) ? data_q[head] : mem_data_o;
    mem_en_d   = state_d != IDLE;
    mem_wr_d   = state_d == WR;
    empty_d    = wb_count_o == '0 && state == IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      head         <= '0;
      tail         <= '0;
      wb_count_o   <= '0;
      rd_pend      <= 1'b0;
      rd_line      <= '0;
      up_ack_o     <= 1'b0;
      up_data_o    <= '0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      wb_empty_o   <= 1'b1;
    end else begin
      head         <= head + PW'(pop);
      tail         <= tail + PW'(push);
      wb_count_o   <= wb_count_o + (PW+1)'(push) - (PW+1)'(pop);
      rd_pend      <= rd_miss || (rd_pend && !rd_done);
      rd_line      <= rd_miss ? up_line : rd_line;
      up_ack_o     <= up_ack_d;
      up_data_o    <= up_data_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      mem_enable_o <= mem_en_d;
      mem_write_o  <= mem_wr_d;
      wb_empty_o   <= empty_d;
    end
  always_ff @(posedge clk_i)
    if (push) begin
      line_q[tail] <= up_line;
      data_q[tail] <= up_data_i;
    end else if (merge) data_q[wsel] <= up_data_i;
endmodule
